// File: rtl/hms_time_counter_pkg.sv
// Shared mode encodings and BCD field limits for the HMS time-of-day counter.
package hms_time_counter_pkg;

  typedef enum logic [1:0] {
    ModeRun     = 2'd0,
    ModeSetHour = 2'd1,
    ModeSetMin  = 2'd2
  } mode_e;

  localparam logic [7:0] SecMax  = 8'h59;
  localparam logic [7:0] MinMax  = 8'h59;
  localparam logic [7:0] HourMax = 8'h23;

endpackage

// File: rtl/hms_time_counter_bcd_mod_counter.sv
// Two-digit BCD modulo counter: wraps to 00 after MaxBcd and flags the carry on that increment.
module bcd_mod_counter #(
  parameter logic [7:0] MaxBcd = 8'h59
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       inc_i,
  output logic [7:0] value_o,
  output logic       carry_o
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (inc_i) begin
      if (value_q == MaxBcd) begin
        value_d = '0;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign carry_o = inc_i & ~clear_i & (value_q == MaxBcd);

endmodule

// File: rtl/hms_time_counter.sv
// BCD hours:minutes:seconds counter advanced by rising edges of the divided clock,
// with a key-driven set mode for hours and minutes.
module hms_time_counter
  import hms_time_counter_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned PRESC_WIDTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_div_clk,
  input  logic       i_key_mode,
  input  logic       i_key_inc,
  output logic [7:0] o_hour_bcd,
  output logic [7:0] o_min_bcd,
  output logic [7:0] o_sec_bcd,
  output logic [1:0] o_mode,
  output logic       o_sec_pulse,
  output logic       o_day_pulse
);

  localparam logic [PRESC_WIDTH-1:0] PrescLast = PRESC_WIDTH'(TICKS_PER_SEC - 1);

  mode_e                  mode_q, mode_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic                   div_d1_q, div_d2_q;
  logic                   sec_pulse_q, day_pulse_q;
  logic                   tick, sec_adv, sec_clr, set_hour_inc, set_min_inc, run;
  logic                   sec_carry, min_carry, hour_carry, min_inc, hour_inc;

  assign tick = div_d1_q & ~div_d2_q;
  assign run  = (mode_q == ModeRun);

  // A key_mode press always wins over a same-cycle tick or increment.
  always_comb begin
    mode_d       = mode_q;
    presc_d      = presc_q;
    sec_adv      = 1'b0;
    sec_clr      = 1'b0;
    set_hour_inc = 1'b0;
    set_min_inc  = 1'b0;
    unique case (mode_q)
      ModeRun: begin
        if (i_key_mode) begin
          mode_d  = ModeSetHour;
          sec_clr = 1'b1;
          presc_d = '0;
        end else if (tick) begin
          if (presc_q == PrescLast) begin
            presc_d = '0;
            sec_adv = 1'b1;
          end else begin
            presc_d = presc_q + PRESC_WIDTH'(1);
          end
        end
      end
      ModeSetHour: begin
        if (i_key_mode) begin
          mode_d = ModeSetMin;
        end else if (i_key_inc) begin
          set_hour_inc = 1'b1;
        end
      end
      ModeSetMin: begin
        if (i_key_mode) begin
          mode_d  = ModeRun;
          presc_d = '0;
        end else if (i_key_inc) begin
          set_min_inc = 1'b1;
        end
      end
      default: mode_d = ModeRun;
    endcase
  end

  // Carries only ripple upward in RUN; set-mode wraps stay within their field.
  assign min_inc  = sec_carry | set_min_inc;
  assign hour_inc = (run & min_carry) | set_hour_inc;

  bcd_mod_counter #(.MaxBcd(SecMax)) u_sec (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .clear_i (sec_clr),
    .inc_i   (sec_adv),
    .value_o (o_sec_bcd),
    .carry_o (sec_carry)
  );

  bcd_mod_counter #(.MaxBcd(MinMax)) u_min (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .clear_i (1'b0),
    .inc_i   (min_inc),
    .value_o (o_min_bcd),
    .carry_o (min_carry)
  );

  bcd_mod_counter #(.MaxBcd(HourMax)) u_hour (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .clear_i (1'b0),
    .inc_i   (hour_inc),
    .value_o (o_hour_bcd),
    .carry_o (hour_carry)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mode_q      <= ModeRun;
      presc_q     <= '0;
      div_d1_q    <= 1'b0;
      div_d2_q    <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      div_d1_q    <= i_div_clk;
      div_d2_q    <= div_d1_q;
      sec_pulse_q <= sec_adv;
      day_pulse_q <= run & hour_carry;
    end
  end

  assign o_mode      = mode_q;
  assign o_sec_pulse = sec_pulse_q;
  assign o_day_pulse = day_pulse_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: two instances (1 and 4 ticks per second) share stimulus and are
// compared every cycle against a seconds-of-day reference model.
module tb_hms_time_counter;

  logic       clk, rst_n, div, km, ki;
  logic [7:0] hour1, min1, sec1, hour4, min4, sec4;
  logic [1:0] mode1, mode4;
  logic       secp1, dayp1, secp4, dayp4;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds of day, mode as 0/1/2, prescaler as tick count.
  int t[2], md[2], pr[2];
  int tps[2] = '{1, 4};
  bit sp[2], dp[2];
  bit samp1, samp2;
  int sec_cnt1, sec_cnt4, day_cnt1;

  hms_time_counter #(.TICKS_PER_SEC(1), .PRESC_WIDTH(4)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_div_clk(div), .i_key_mode(km), .i_key_inc(ki),
    .o_hour_bcd(hour1), .o_min_bcd(min1), .o_sec_bcd(sec1), .o_mode(mode1),
    .o_sec_pulse(secp1), .o_day_pulse(dayp1)
  );

  hms_time_counter #(.TICKS_PER_SEC(4), .PRESC_WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_div_clk(div), .i_key_mode(km), .i_key_inc(ki),
    .o_hour_bcd(hour4), .o_min_bcd(min4), .o_sec_bcd(sec4), .o_mode(mode4),
    .o_sec_pulse(secp4), .o_day_pulse(dayp4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      t[k] = 0; md[k] = 0; pr[k] = 0; sp[k] = 0; dp[k] = 0;
    end
    samp1 = 0;
    samp2 = 0;
  endtask

  task automatic model_update(input int k, input bit tick, input bit m, input bit i);
    sp[k] = 0;
    dp[k] = 0;
    case (md[k])
      0: begin
        if (m) begin
          md[k] = 1;
          t[k]  = t[k] - t[k] % 60;
          pr[k] = 0;
        end else if (tick) begin
          if (pr[k] == tps[k] - 1) begin
            pr[k] = 0;
            sp[k] = 1;
            dp[k] = (t[k] == 86399);
            t[k]  = (t[k] + 1) % 86400;
          end else begin
            pr[k]++;
          end
        end
      end
      1: begin
        if (m) md[k] = 2;
        else if (i) t[k] = ((t[k] / 3600 + 1) % 24) * 3600 + t[k] % 3600;
      end
      default: begin
        if (m) begin
          md[k] = 0;
          pr[k] = 0;
        end else if (i) begin
          t[k] = (t[k] / 3600) * 3600 + (((t[k] / 60) % 60 + 1) % 60) * 60 + t[k] % 60;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("hour1", hour1, bcd(t[0] / 3600));
    chk("min1", min1, bcd((t[0] / 60) % 60));
    chk("sec1", sec1, bcd(t[0] % 60));
    chk("mode1", {6'd0, mode1}, 8'(md[0]));
    chk("secp1", {7'd0, secp1}, {7'd0, sp[0]});
    chk("dayp1", {7'd0, dayp1}, {7'd0, dp[0]});
    chk("hour4", hour4, bcd(t[1] / 3600));
    chk("min4", min4, bcd((t[1] / 60) % 60));
    chk("sec4", sec4, bcd(t[1] % 60));
    chk("mode4", {6'd0, mode4}, 8'(md[1]));
    chk("secp4", {7'd0, secp4}, {7'd0, sp[1]});
    chk("dayp4", {7'd0, dayp4}, {7'd0, dp[1]});
  endtask

  // One clock cycle: drive at negedge, model and DUT advance at posedge, compare 1ns later.
  task automatic step(input bit d, input bit m, input bit i);
    bit tick;
    div = d; km = m; ki = i;
    @(posedge clk);
    tick  = samp1 & ~samp2;
    samp2 = samp1;
    samp1 = d;
    model_update(0, tick, m, i);
    model_update(1, tick, m, i);
    #1;
    sec_cnt1 += int'(secp1);
    sec_cnt4 += int'(secp4);
    day_cnt1 += int'(dayp1);
    check_all();
    @(negedge clk);
    km = 1'b0;
    ki = 1'b0;
  endtask

  task automatic period();
    int hi, lo;
    hi = $urandom_range(1, 3);
    lo = $urandom_range(1, 3);
    repeat (hi) step(1, 0, 0);
    repeat (lo) step(0, 0, 0);
  endtask

  task automatic set_hm(input int h, input int m);
    step(0, 1, 0);
    for (int n = 0; n < 30 && (t[0] / 3600) != h; n++) step(0, 0, 1);
    step(0, 1, 0);
    for (int n = 0; n < 70 && ((t[0] / 60) % 60) != m; n++) step(0, 0, 1);
    step(0, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0; div = 1'b0; km = 1'b0; ki = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running seconds with one tick per second.
    sec_cnt1 = 0;
    repeat (60) period();
    chk("t1_secpulses", 8'(sec_cnt1), 8'd60);
    chk("t1_min", min1, 8'h01);
    chk("t1_sec", sec1, 8'h00);

    // Day rollover.
    set_hm(23, 59);
    repeat (58) period();
    chk("t2_sec58", sec1, 8'h58);
    day_cnt1 = 0;
    repeat (2) period();
    chk("t2_dayroll", {hour1[7:0]} | min1 | sec1, 8'h00);
    chk("t2_daypulses", 8'(day_cnt1), 8'd1);

    // Set hours and minutes with noise on the divided clock.
    step(0, 1, 0);
    chk("t3_sec_clr", sec1, 8'h00);
    repeat (25) step(1'($urandom_range(0, 1)), 0, 1);
    chk("t3_hour", hour1, 8'h01);
    step(0, 1, 0);
    repeat (61) step(1'($urandom_range(0, 1)), 0, 1);
    chk("t3_min", min1, 8'h01);
    chk("t3_hour_keep", hour1, 8'h01);

    // Mode and inc together; four-tick prescaler restart.
    step(0, 1, 1);
    chk("t4_mode", {6'd0, mode1}, 8'h00);
    chk("t4_min", min1, 8'h01);
    sec_cnt4 = 0;
    repeat (3) period();
    chk("t4_nopulse", 8'(sec_cnt4), 8'd0);
    period();
    chk("t4_pulse", 8'(sec_cnt4), 8'd1);

    // Asynchronous reset mid-count, released with the divider already high.
    set_hm(12, 34);
    repeat (56) period();
    chk("t5_pre", sec1, 8'h56);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    div = 1'b1;
    rst_n = 1'b1;
    repeat (3) step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    chk("t5_onetick", sec1, 8'h01);

    // Inc ignored in RUN; units-to-tens carry.
    repeat (5) step(0, 0, 1);
    chk("t6_noinc", sec1, 8'h01);
    repeat (8) period();
    chk("t6_sec09", sec1, 8'h09);
    period();
    chk("t6_sec10", sec1, 8'h10);

    // Random mix of divider activity and key pulses.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) div = ~div;
      step(div, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
